obf_key_loader: RTL and testbench

OBF_KEY_LOADER -- requirements
Module: obf_key_loader

---
 rtl/obf_key_loader.sv | 148 ++++++++++++++
 tb/tb_obf_key_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obf_key_loader.sv
// Serial key loader for the locked c499 core: fetches KEY_W bits LSB first,
// commits them atomically. Define OBF_KEY_PARITY_EN to add an even-parity bit.
module obf_key_loader #(
    parameter int KEY_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             kreq,
    input  logic             kvalid,
    input  logic             kdata,
    output logic [KEY_W-1:0] key,
    output logic             key_ready,
    output logic             busy,
    output logic             err
);

`ifdef OBF_KEY_PARITY_EN
    localparam int NBITS = KEY_W + 1;
`else
    localparam int NBITS = KEY_W;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bcnt;
    logic [TW-1:0]    tcnt;
    logic [NBITS-1:0] shadow;
    logic             xfer;
    logic             last_bit;
    logic             tmo;
    logic             accept;
    logic             pass;

    assign kreq     = (state == LOAD);
    assign busy     = (state == LOAD) || (state == CHECK);
    assign xfer     = kreq && kvalid;
    assign last_bit = (bcnt == CW'(NBITS - 1));
    assign tmo      = kreq && !kvalid && (tcnt == TW'(TIMEOUT - 1));
    assign accept   = start &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef OBF_KEY_PARITY_EN
    // Parity bit makes the total number of ones even.
    assign pass = ((^shadow[KEY_W-1:0]) == shadow[KEY_W]);
`else
    assign pass = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; terminal states wait for start.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (xfer && last_bit) begin
                    state_nxt = CHECK;
                end else if (tmo) begin
                    state_nxt = ERR;
                end
            end
            CHECK: begin
                state_nxt = pass ? DONE : ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter, idle-cycle counter and shadow register; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt   <= '0;
            tcnt   <= '0;
            shadow <= '0;
        end else if (accept) begin
            bcnt   <= '0;
            tcnt   <= '0;
            shadow <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NBITS; i++) begin
                if (bcnt == CW'(i)) begin
                    shadow[i] <= kdata;
                end
            end
            if (bcnt != CW'(NBITS)) begin
                bcnt <= bcnt + 1'b1;
            end
            tcnt <= '0;
        end else if (kreq) begin
            if (tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Committed key and status flags; key only changes at the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= '0;
            key_ready <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            key       <= '0;
            key_ready <= 1'b0;
            err       <= 1'b0;
        end else if (state == CHECK) begin
            if (pass) begin
                key       <= shadow[KEY_W-1:0];
                key_ready <= 1'b1;
            end else begin
                key       <= '0;
                key_ready <= 1'b0;
                err       <= 1'b1;
            end
        end else if (tmo) begin
            key       <= '0;
            key_ready <= 1'b0;
            err       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obf_key_loader.sv
// Randomized scoreboard bench for obf_key_loader.
// Honours OBF_KEY_PARITY_EN when defined for both bench and design.
module tb_obf_key_loader;

    localparam int KW = 16;
    localparam int TO = 64;
`ifdef OBF_KEY_PARITY_EN
    localparam int NB = KW + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = KW;
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          kreq;
    logic          kvalid;
    logic          kdata;
    logic [KW-1:0] key;
    logic          key_ready;
    logic          busy;
    logic          err;

    typedef struct {
        bit            is_err;
        logic [KW-1:0] k;
    } exp_t;

    exp_t sb[$];
    int   gap[NB];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    obf_key_loader #(
        .KEY_W  (KW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .kreq     (kreq),
        .kvalid   (kvalid),
        .kdata    (kdata),
        .key      (key),
        .key_ready(key_ready),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Pops one expectation each time a load finishes (key_ready or err rises).
    task automatic monitor();
        logic pr = 1'b0;
        logic pe = 1'b0;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (busy === 1'b1) chk("key_locked", key, 0);
            if ((key_ready && !pr) || (err && !pe)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got rdy=%b err=%b, expected none",
                             key_ready, err);
                end else begin
                    e = sb.pop_front();
                    chk("sb_err", err, e.is_err);
                    chk("sb_ready", key_ready, !e.is_err);
                    chk("sb_key", key, e.k);
                end
            end
            pr = key_ready;
            pe = err;
        end
    endtask

    // One load: reference outcome pushed first, then the stream is driven.
    task automatic do_load(input logic [KW-1:0] k, input bit flip,
                           input int abort_at, input int start_at);
        logic [NB-1:0] bits;
        int            busy_n = 0;
        int            gsum = 0;
        int            tmo_bit = -1;
        bit            exp_err;
        bits[KW-1:0] = k;
`ifdef OBF_KEY_PARITY_EN
        bits[KW] = (^k) ^ flip;
`endif
        for (int i = 0; i < NB; i++) begin
            gsum += gap[i];
            if (tmo_bit < 0 && gap[i] >= TO) tmo_bit = i;
        end
        exp_err = (tmo_bit >= 0) || (PAR && flip);
        if (abort_at < 0) begin
            if (exp_err) sb.push_back('{1'b1, '0});
            else sb.push_back('{1'b0, k});
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_clr", {err, key_ready, busy, key}, {1'b0, 1'b0, 1'b1, 16'h0});
        for (int i = 0; i < NB; i++) begin
            if (i == abort_at) begin
                kvalid = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk("rst_async", {key, key_ready, busy, err, kreq}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            for (int g = 0; g < gap[i] && g < TO; g++) begin
                kvalid = 1'b0;
                kdata  = 1'($urandom);
                @(negedge clk);
                busy_n += int'(busy);
                chk("kreq_idle", kreq, 1);
                @(posedge clk);
                #1;
            end
            if (gap[i] >= TO) begin
                @(negedge clk);
                chk("tmo_state", {err, kreq, busy, key_ready, key},
                    {1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
                @(posedge clk);
                #1;
                return;
            end
            kvalid = 1'b1;
            kdata  = bits[i];
            if (i == start_at) start = 1'b1;
            @(negedge clk);
            busy_n += int'(busy);
            chk("kreq_xfer", kreq, 1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        kvalid = 1'($urandom);
        kdata  = 1'($urandom);
        if (start_at == NB) start = 1'b1;
        @(negedge clk);
        busy_n += int'(busy);
        chk("check_cyc", {busy, kreq, key_ready, err}, 4'b1000);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_ready", key_ready, !exp_err);
        chk("lat_err", err, exp_err);
        chk("end_busy", busy, 0);
        chk("busy_cycles", busy_n, gsum + NB + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < NB; i++) gap[i] = 0;
    endtask

    task automatic run();
        logic [KW-1:0] k;
        rst_n  = 1'b0;
        start  = 1'b0;
        kvalid = 1'b0;
        kdata  = 1'b0;
        #12;
        chk("reset_state", {key, key_ready, busy, err, kreq}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            kvalid = 1'($urandom);
            kdata  = 1'($urandom);
            @(negedge clk);
            chk("idle_hold", {kreq, busy, key_ready, err}, 0);
        end
        @(posedge clk);
        #1;
        kvalid = 1'b0;

        clear_gaps();
        do_load(16'hA5C3, 1'b0, -1, -1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("done_hold", {key_ready, key}, {1'b1, 16'hA5C3});
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < NB; i++) gap[i] = (i == 0) ? 0 : 2;
        do_load(16'hA5C3, 1'b0, -1, -1);

        clear_gaps();
        gap[0] = TO;
        do_load(16'h1234, 1'b0, -1, -1);

        clear_gaps();
        gap[7] = TO - 1;
        do_load(16'h3C5A, 1'b0, -1, -1);

        clear_gaps();
        gap[9] = TO;
        do_load(16'h0F0F, 1'b0, -1, -1);

        clear_gaps();
        do_load(16'h0001, 1'b1, -1, -1);
        do_load(16'h0001, 1'b0, -1, -1);

        do_load(16'hA5C3, 1'b0, 8, -1);
        chk("post_rst", {key, key_ready, busy, err, kreq}, 0);
        do_load(16'hFFFF, 1'b0, -1, -1);

        do_load(16'h5A96, 1'b0, -1, 5);
        do_load(16'h8001, 1'b0, -1, NB);

        for (int n = 0; n < 30; n++) begin
            k = 16'($urandom);
            for (int i = 0; i < NB; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 6) gap[i] = 0;
                else if (r < 9) gap[i] = int'($urandom_range(1, 3));
                else gap[i] = int'($urandom_range(4, 10));
            end
            if ($urandom_range(0, 4) == 0)
                gap[$urandom_range(0, NB - 1)] = TO - int'($urandom_range(0, 1));
            do_load(k, ($urandom_range(0, 3) == 0), -1, -1);
        end

        repeat (3) @(posedge clk);
        chk("sb_drain", sb.size(), 0);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
            run();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
